snake_body_engine: RTL and testbench

// Multi-segment successor of the single-box player logic: holds a snake body of up to MAX_LEN

---
 rtl/snake_body_engine.sv | 251 +++++++++++++++++++++++++
 tb/tb_snake_body_engine.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_body_engine.sv
// rtl/snake_body_engine.sv - multi-segment snake body: move FSM, collision scan, cell renderer
module snake_body_engine #(
  parameter int MAX_LEN   = 16,
  parameter int CELL_LOG2 = 3,
  parameter int GRID_W    = 100,
  parameter int GRID_H    = 75,
  parameter int START_X   = 5,
  parameter int START_Y   = 5,
  parameter int START_LEN = 3
) (
  input  logic        uclk,
  input  logic        rst,
  input  logic        move_tick,
  input  logic [2:0]  dir,
  input  logic [6:0]  fruit_x,
  input  logic [6:0]  fruit_y,
  input  logic [7:0]  fruit_rgb,
  input  logic [10:0] pixel_x,
  input  logic [10:0] pixel_y,
  output logic [2:0]  R,
  output logic [2:0]  G,
  output logic [1:0]  B,
  output logic        eat,
  output logic        game_over,
  output logic [6:0]  length,
  output logic        busy
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic signed [7:0] GW8   = 8'(GRID_W);
  localparam logic signed [7:0] GH8   = 8'(GRID_H);
  localparam logic [10:0]       GW11  = 11'(GRID_W);
  localparam logic [10:0]       GH11  = 11'(GRID_H);
  localparam logic [6:0]        MAXL7 = 7'(MAX_LEN);

  localparam logic [2:0] H_UP    = 3'd1;
  localparam logic [2:0] H_DOWN  = 3'd2;
  localparam logic [2:0] H_LEFT  = 3'd3;
  localparam logic [2:0] H_RIGHT = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_SCAN,
    S_COMMIT,
    S_DEAD
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [6:0] r_seg_x [MAX_LEN];
  logic [6:0] r_seg_y [MAX_LEN];
  logic [6:0] r_len;
  logic [2:0] r_heading;

  logic       r_tick_d;
  logic       r_tick_edge;

  logic [6:0] r_nx;
  logic [6:0] r_ny;
  logic       r_grow;
  logic [6:0] r_lim;
  logic [6:0] r_idx;

  logic              w_dir_valid;
  logic              w_reverse;
  logic [2:0]        w_heading;
  logic signed [7:0] w_nx8;
  logic signed [7:0] w_ny8;
  logic              w_off;
  logic              w_grow;
  logic [6:0]        w_lim;
  logic              w_hit;

  logic [10:0] w_cx;
  logic [10:0] w_cy;
  logic        w_in_grid;
  logic        w_head_px;
  logic        w_body_px;
  logic        w_fruit_px;
  logic [7:0]  w_rgb;
  logic [7:0]  r_rgb;

  // Heading selection and next-head arithmetic; a reversal request keeps the current heading.
  always_comb begin
    w_dir_valid = (dir >= H_UP) && (dir <= H_RIGHT);
    w_reverse   = ((dir == H_UP)    && (r_heading == H_DOWN))  ||
                  ((dir == H_DOWN)  && (r_heading == H_UP))    ||
                  ((dir == H_LEFT)  && (r_heading == H_RIGHT)) ||
                  ((dir == H_RIGHT) && (r_heading == H_LEFT));
    w_heading   = (w_dir_valid && !w_reverse) ? dir : r_heading;
    w_nx8       = $signed({1'b0, r_seg_x[0]});
    w_ny8       = $signed({1'b0, r_seg_y[0]});
    case (w_heading)
      H_UP:    w_ny8 = w_ny8 - 8'sd1;
      H_DOWN:  w_ny8 = w_ny8 + 8'sd1;
      H_LEFT:  w_nx8 = w_nx8 - 8'sd1;
      H_RIGHT: w_nx8 = w_nx8 + 8'sd1;
      default: ;
    endcase
    w_off  = (w_nx8 < 8'sd0) || (w_nx8 >= GW8) || (w_ny8 < 8'sd0) || (w_ny8 >= GH8);
    w_grow = (w_nx8[6:0] == fruit_x) && (w_ny8[6:0] == fruit_y);
    // The tail cell is vacated during the move unless the snake grows.
    w_lim  = w_grow ? r_len : (r_len - 7'd1);
    w_hit  = (r_seg_x[r_idx[IW-1:0]] == r_nx) && (r_seg_y[r_idx[IW-1:0]] == r_ny);
  end

  // Move FSM state register.
  always_ff @(posedge uclk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Move FSM next-state and status outputs.
  always_comb begin
    w_next_state = r_state;
    busy         = 1'b1;
    eat          = 1'b0;
    game_over    = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (r_tick_edge) begin
          w_next_state = S_STEP;
        end
      end
      S_STEP: begin
        w_next_state = w_off ? S_DEAD : S_SCAN;
      end
      S_SCAN: begin
        if (r_lim <= 7'd1) begin
          w_next_state = S_COMMIT;
        end else if (w_hit) begin
          w_next_state = S_DEAD;
        end else if (r_idx == (r_lim - 7'd1)) begin
          w_next_state = S_COMMIT;
        end
      end
      S_COMMIT: begin
        eat          = r_grow;
        w_next_state = S_IDLE;
      end
      S_DEAD: begin
        game_over    = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Registered rising-edge detect on the move request.
  always_ff @(posedge uclk) begin
    if (rst) begin
      r_tick_d    <= 1'b0;
      r_tick_edge <= 1'b0;
    end else begin
      r_tick_d    <= move_tick;
      r_tick_edge <= move_tick & ~r_tick_d;
    end
  end

  // Per-move scratch: candidate head, grow flag, scan limit and scan index.
  always_ff @(posedge uclk) begin
    if (rst) begin
      r_nx   <= 7'd0;
      r_ny   <= 7'd0;
      r_grow <= 1'b0;
      r_lim  <= 7'd0;
      r_idx  <= 7'd1;
    end else if (r_state == S_STEP) begin
      r_nx   <= w_nx8[6:0];
      r_ny   <= w_ny8[6:0];
      r_grow <= w_grow;
      r_lim  <= w_lim;
      r_idx  <= 7'd1;
    end else if (r_state == S_SCAN) begin
      r_idx  <= r_idx + 7'd1;
    end
  end

  // Committed body, length and heading; restored to the start pose on reset or death.
  always_ff @(posedge uclk) begin
    if (rst || (r_state == S_DEAD)) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= 7'(START_X - i);
        r_seg_y[i] <= 7'(START_Y);
      end
      r_len     <= 7'(START_LEN);
      r_heading <= H_RIGHT;
    end else if (r_state == S_STEP) begin
      r_heading <= w_heading;
    end else if (r_state == S_COMMIT) begin
      for (int i = 1; i < MAX_LEN; i++) begin
        r_seg_x[i] <= r_seg_x[i-1];
        r_seg_y[i] <= r_seg_y[i-1];
      end
      r_seg_x[0] <= r_nx;
      r_seg_y[0] <= r_ny;
      if (r_grow && (r_len < MAXL7)) begin
        r_len <= r_len + 7'd1;
      end
    end
  end

  // Cell lookup for the current pixel with head > body > fruit > background priority.
  always_comb begin
    w_cx       = pixel_x >> CELL_LOG2;
    w_cy       = pixel_y >> CELL_LOG2;
    w_in_grid  = (w_cx < GW11) && (w_cy < GH11);
    w_head_px  = (w_cx == {4'b0, r_seg_x[0]}) && (w_cy == {4'b0, r_seg_y[0]});
    w_body_px  = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((7'(i) < r_len) && (w_cx == {4'b0, r_seg_x[i]}) && (w_cy == {4'b0, r_seg_y[i]})) begin
        w_body_px = 1'b1;
      end
    end
    w_fruit_px = (w_cx == {4'b0, fruit_x}) && (w_cy == {4'b0, fruit_y});
    if (!w_in_grid) begin
      w_rgb = 8'h00;
    end else if (w_head_px) begin
      w_rgb = 8'h03;
    end else if (w_body_px) begin
      w_rgb = 8'h1C;
    end else if (w_fruit_px) begin
      w_rgb = fruit_rgb;
    end else begin
      w_rgb = 8'hFF;
    end
  end

  // Registered pixel colour.
  always_ff @(posedge uclk) begin
    if (rst) begin
      r_rgb <= 8'hFF;
    end else begin
      r_rgb <= w_rgb;
    end
  end

  assign R      = r_rgb[7:5];
  assign G      = r_rgb[4:2];
  assign B      = r_rgb[1:0];
  assign length = r_len;

endmodule

// File: tb/tb_snake_body_engine.sv
// tb/tb_snake_body_engine.sv - self-checking bench for snake_body_engine
module tb_snake_body_engine;

  logic        uclk = 1'b0;
  logic        rst;
  logic        move_tick;
  logic [2:0]  dir;
  logic [6:0]  fruit_x;
  logic [6:0]  fruit_y;
  logic [7:0]  fruit_rgb;
  logic [10:0] pixel_x;
  logic [10:0] pixel_y;
  logic [2:0]  R;
  logic [2:0]  G;
  logic [1:0]  B;
  logic        eat;
  logic        game_over;
  logic [6:0]  length;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: body as coordinate queues, head first.
  int mx[$];
  int my[$];
  int mhead;

  snake_body_engine dut (
    .uclk      (uclk),
    .rst       (rst),
    .move_tick (move_tick),
    .dir       (dir),
    .fruit_x   (fruit_x),
    .fruit_y   (fruit_y),
    .fruit_rgb (fruit_rgb),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .R         (R),
    .G         (G),
    .B         (B),
    .eat       (eat),
    .game_over (game_over),
    .length    (length),
    .busy      (busy)
  );

  always #5 uclk = ~uclk;

  function automatic void model_reset();
    mx = {};
    my = {};
    for (int i = 0; i < 3; i++) begin
      mx.push_back(5 - i);
      my.push_back(5);
    end
    mhead = 4;
  endfunction

  function automatic int next_heading(input int d);
    bit rev;
    rev = (d == 1 && mhead == 2) || (d == 2 && mhead == 1) ||
          (d == 3 && mhead == 4) || (d == 4 && mhead == 3);
    if (d >= 1 && d <= 4 && !rev) return d;
    return mhead;
  endfunction

  function automatic void model_step(input int d, output bit e_go, output bit e_eat);
    int  nx, ny, last;
    bit  grow;
    e_go  = 1'b0;
    e_eat = 1'b0;
    mhead = next_heading(d);
    nx = mx[0] + ((mhead == 4) ? 1 : 0) - ((mhead == 3) ? 1 : 0);
    ny = my[0] + ((mhead == 2) ? 1 : 0) - ((mhead == 1) ? 1 : 0);
    if (nx < 0 || nx >= 100 || ny < 0 || ny >= 75) begin
      e_go = 1'b1;
      model_reset();
      return;
    end
    grow = (nx == int'(fruit_x)) && (ny == int'(fruit_y));
    last = grow ? mx.size() - 1 : mx.size() - 2;
    for (int i = 1; i <= last; i++) begin
      if (mx[i] == nx && my[i] == ny) begin
        e_go = 1'b1;
        model_reset();
        return;
      end
    end
    mx.push_front(nx);
    my.push_front(ny);
    if (!grow || mx.size() > 16) begin
      void'(mx.pop_back());
      void'(my.pop_back());
    end
    e_eat = grow;
  endfunction

  function automatic logic [7:0] exp_rgb(input int px, input int py);
    int cx, cy;
    cx = px / 8;
    cy = py / 8;
    if (cx >= 100 || cy >= 75) return 8'h00;
    if (cx == mx[0] && cy == my[0]) return 8'h03;
    for (int i = 1; i < mx.size(); i++) begin
      if (cx == mx[i] && cy == my[i]) return 8'h1C;
    end
    if (cx == int'(fruit_x) && cy == int'(fruit_y)) return fruit_rgb;
    return 8'hFF;
  endfunction

  task automatic probe_px(input int px, input int py, input logic [7:0] exp, input string tag);
    logic [7:0] got;
    @(negedge uclk);
    pixel_x = 11'(px);
    pixel_y = 11'(py);
    @(posedge uclk);
    #1;
    got = {R, G, B};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s pixel(%0d,%0d) rgb got %h expected %h", tag, px, py, got, exp);
    end
  endtask

  task automatic check_body(input string tag);
    int px, py;
    n_checks++;
    if (length !== 7'(mx.size())) begin
      n_fail++;
      $display("FAIL %s length got %0d expected %0d", tag, length, mx.size());
    end
    for (int i = 0; i < mx.size(); i++) begin
      probe_px(mx[i] * 8 + 3, my[i] * 8 + 4, exp_rgb(mx[i] * 8 + 3, my[i] * 8 + 4), tag);
    end
    probe_px(int'(fruit_x) * 8 + 7, int'(fruit_y) * 8, exp_rgb(int'(fruit_x) * 8 + 7, int'(fruit_y) * 8), tag);
    for (int k = 0; k < 2; k++) begin
      px = (mx[0] + int'($urandom_range(0, 6)) - 3) * 8 + int'($urandom_range(0, 7));
      py = (my[0] + int'($urandom_range(0, 6)) - 3) * 8 + int'($urandom_range(0, 7));
      if (px < 0) px = 0;
      if (py < 0) py = 0;
      probe_px(px, py, exp_rgb(px, py), tag);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    move_tick = 1'b0;
    repeat (2) @(posedge uclk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic set_fruit(input int x, input int y);
    fruit_x = 7'(x);
    fruit_y = 7'(y);
  endtask

  task automatic do_move(input logic [2:0] d, input bit glitch, input string tag);
    int n_eat, n_go;
    bit saw_busy, done, extra, e_go, e_eat;
    n_eat    = 0;
    n_go     = 0;
    saw_busy = 1'b0;
    done     = 1'b0;
    dir      = d;
    @(posedge uclk);
    #1;
    move_tick = 1'b1;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge uclk);
      if (c == 1) move_tick = 1'b0;
      if (glitch && c == 2) move_tick = 1'b1;
      if (glitch && c == 3) move_tick = 1'b0;
      if (eat) n_eat++;
      if (game_over) n_go++;
      if (busy) saw_busy = 1'b1;
      else if (saw_busy) done = 1'b1;
    end
    move_tick = 1'b0;
    model_step(int'(d), e_go, e_eat);
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s move completion got timeout expected busy to fall", tag);
    end
    n_checks++;
    if (n_eat != int'(e_eat)) begin
      n_fail++;
      $display("FAIL %s eat pulses got %0d expected %0d", tag, n_eat, e_eat);
    end
    n_checks++;
    if (n_go != int'(e_go)) begin
      n_fail++;
      $display("FAIL %s game_over pulses got %0d expected %0d", tag, n_go, e_go);
    end
    if (glitch) begin
      extra = 1'b0;
      repeat (8) begin
        @(negedge uclk);
        if (busy) extra = 1'b1;
      end
      n_checks++;
      if (extra) begin
        n_fail++;
        $display("FAIL %s second step busy got 1 expected 0", tag);
      end
    end
    check_body(tag);
  endtask

  task automatic test_reset();
    fruit_rgb = 8'hE0;
    set_fruit(50, 50);
    pixel_x = 11'd0;
    pixel_y = 11'd0;
    dir     = 3'd0;
    rst     = 1'b1;
    move_tick = 1'b0;
    repeat (3) @(posedge uclk);
    @(negedge uclk);
    n_checks++;
    if ({R, G, B} !== 8'hFF) begin n_fail++; $display("FAIL reset_rgb got %h expected ff", {R, G, B}); end
    n_checks++;
    if ({eat, game_over, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b expected 000", {eat, game_over, busy}); end
    n_checks++;
    if (length !== 7'd3) begin n_fail++; $display("FAIL reset_length got %0d expected 3", length); end
    #1;
    rst = 1'b0;
    model_reset();
    check_body("reset_pose");
  endtask

  task automatic test_step_and_render();
    do_reset();
    set_fruit(50, 50);
    do_move(3'd4, 1'b0, "step_right");
    probe_px(48, 40, 8'h03, "render_head");
    probe_px(40, 40, 8'h1C, "render_body");
    probe_px(32, 40, 8'h1C, "render_tail");
    probe_px(24, 40, 8'hFF, "render_vacated");
    probe_px(900, 10, 8'h00, "render_off_x");
    probe_px(800, 10, 8'h00, "render_x_edge");
    probe_px(799, 599, 8'hFF, "render_last_cell");
    probe_px(10, 600, 8'h00, "render_y_edge");
    probe_px(400, 400, 8'hE0, "render_fruit");
  endtask

  task automatic test_grow();
    do_reset();
    set_fruit(6, 5);
    do_move(3'd4, 1'b0, "grow");
    n_checks++;
    if (length !== 7'd4) begin n_fail++; $display("FAIL grow_length got %0d expected 4", length); end
    probe_px(3 * 8, 5 * 8, 8'h1C, "grow_tail_kept");
  endtask

  task automatic test_no_reversal();
    do_reset();
    set_fruit(50, 50);
    do_move(3'd4, 1'b0, "rev_first");
    do_move(3'd3, 1'b0, "rev_ignored");
    probe_px(7 * 8, 5 * 8, 8'h03, "rev_head");
    do_move(3'd1, 1'b0, "turn_up");
    probe_px(7 * 8, 4 * 8, 8'h03, "turn_up_head");
    do_move(3'd0, 1'b0, "keep_heading");
    probe_px(7 * 8, 3 * 8, 8'h03, "keep_head");
  endtask

  task automatic test_wall();
    do_reset();
    set_fruit(0, 70);
    for (int i = 0; i < 94; i++) do_move(3'd4, 1'b0, "to_wall");
    probe_px(99 * 8, 5 * 8, 8'h03, "wall_head_99");
    do_move(3'd4, 1'b0, "wall_hit");
    n_checks++;
    if (length !== 7'd3) begin n_fail++; $display("FAIL wall_length got %0d expected 3", length); end
    probe_px(5 * 8, 5 * 8, 8'h03, "wall_restart_head");
    do_move(3'd1, 1'b0, "wall_after_restart_up");
  endtask

  task automatic test_self_collision();
    do_reset();
    set_fruit(6, 5);
    do_move(3'd4, 1'b0, "curl_grow1");
    set_fruit(7, 5);
    do_move(3'd4, 1'b0, "curl_grow2");
    set_fruit(60, 60);
    do_move(3'd1, 1'b0, "curl_up");
    do_move(3'd3, 1'b0, "curl_left");
    do_move(3'd2, 1'b0, "curl_bite");
    n_checks++;
    if (length !== 7'd3) begin n_fail++; $display("FAIL curl_length got %0d expected 3", length); end
    do_reset();
    set_fruit(6, 5);
    do_move(3'd4, 1'b0, "tail_grow");
    set_fruit(60, 60);
    do_move(3'd1, 1'b0, "tail_up");
    do_move(3'd3, 1'b0, "tail_left");
    do_move(3'd2, 1'b0, "tail_chase");
    n_checks++;
    if (length !== 7'd4) begin n_fail++; $display("FAIL tail_chase_length got %0d expected 4", length); end
    set_fruit(6, 5);
    do_move(3'd4, 1'b0, "tail_fruit_bite");
    n_checks++;
    if (length !== 7'd3) begin n_fail++; $display("FAIL tail_fruit_length got %0d expected 3", length); end
  endtask

  task automatic test_max_len();
    do_reset();
    for (int i = 0; i < 14; i++) begin
      set_fruit(mx[0] + 1, 5);
      do_move(3'd4, 1'b0, "max_grow");
    end
    n_checks++;
    if (length !== 7'd16) begin n_fail++; $display("FAIL max_length got %0d expected 16", length); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_fruit(50, 50);
    do_move(3'd4, 1'b1, "busy_edge");
    probe_px(6 * 8, 5 * 8, 8'h03, "busy_edge_head");
    probe_px(7 * 8, 5 * 8, 8'hFF, "busy_edge_no_second");
  endtask

  task automatic test_reset_mid_move();
    bit pulse;
    do_reset();
    set_fruit(6, 5);
    dir = 3'd4;
    pulse = 1'b0;
    @(posedge uclk);
    #1;
    move_tick = 1'b1;
    repeat (2) @(posedge uclk);
    #1;
    rst = 1'b1;
    repeat (3) begin
      @(negedge uclk);
      if (eat || game_over) pulse = 1'b1;
    end
    rst = 1'b0;
    move_tick = 1'b0;
    model_reset();
    repeat (4) begin
      @(negedge uclk);
      if (eat || game_over || busy) pulse = 1'b1;
    end
    n_checks++;
    if (pulse) begin n_fail++; $display("FAIL midreset_pulses got 1 expected 0"); end
    check_body("midreset_pose");
  endtask

  task automatic test_random();
    int d, h, nx, ny;
    do_reset();
    for (int m = 0; m < 220; m++) begin
      d = int'($urandom_range(0, 9));
      if (d > 6) d = mhead;
      if ($urandom_range(0, 2) == 0) begin
        h  = next_heading(d);
        nx = mx[0] + ((h == 4) ? 1 : 0) - ((h == 3) ? 1 : 0);
        ny = my[0] + ((h == 2) ? 1 : 0) - ((h == 1) ? 1 : 0);
        set_fruit(nx, ny);
      end else begin
        set_fruit(int'($urandom_range(0, 99)), int'($urandom_range(0, 74)));
      end
      fruit_rgb = 8'($urandom_range(32, 200));
      do_move(3'(d), 1'b0, "random_move");
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_step_and_render();
    test_grow();
    test_no_reversal();
    test_wall();
    test_self_collision();
    test_max_len();
    test_back_to_back();
    test_reset_mid_move();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
